writeback_queue: RTL and testbench

//  Write-side master for the 32x32 register file: buffers completed results (dest reg + data) from
//  EX/MEM, drains them in order, one per cycle, onto the register-file write port, and supplies

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fwd_match.sv | 34 +++
 rtl/writeback_queue.sv | 100 ++++++++++
 tb/tb_writeback_queue.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]     rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Age-ordered forwarding lookup over the queued writebacks for one decode read port.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  wb_entry_t [DEPTH-1:0]         entries,
    input  logic [DEPTH-1:0]              valid,
    input  logic [$clog2(DEPTH)-1:0]      rd_ptr,
    input  logic [REG_W-1:0]              addr,
    output logic                          hit,
    output logic [DATA_W-1:0]             data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest; a later match overrides, so the youngest entry wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (valid[idx] && (entries[idx].rd == addr) && (addr != REG_ZERO)) begin
                hit  = 1'b1;
                data = DATA_W'(entries[idx].data);
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback buffer between MEM/WB and the register file, with decode forwarding.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REG_W-1:0]             in_reg,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         drain_en,
    output logic                         rf_reg_write,
    output logic [REG_W-1:0]             rf_write_reg,
    output logic [DATA_W-1:0]            rf_write_data,
    input  logic [REG_W-1:0]             fwd_reg1,
    input  logic [REG_W-1:0]             fwd_reg2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;

    logic      not_empty;
    logic      accept;
    logic      store;
    logic      pop;
    wb_entry_t head;

    // Ready is a pure function of occupancy; a same-cycle pop never frees a full queue.
    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign store     = accept & (in_reg != REG_ZERO);
    assign pop       = not_empty & drain_en;

    assign head          = entries[rd_ptr];
    assign rf_reg_write  = pop;
    assign rf_write_reg  = not_empty ? head.rd : REG_ZERO;
    assign rf_write_data = not_empty ? DATA_W'(head.data) : '0;
    assign count         = count_q;

    // Pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid   <= '0;
        end else begin
            if (store) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                valid[rd_ptr] <= 1'b0;
            end
            count_q <= count_q + CNT_W'(store) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (store) begin
            entries[wr_ptr] <= '{rd: in_reg, data: WB_DATA_W'(in_data)};
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fwd1 (
        .entries (entries),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .addr    (fwd_reg1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fwd2 (
        .entries (entries),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .addr    (fwd_reg2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a queue-based reference model plus an independent write monitor.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_reg = '0;
    logic [DW-1:0] in_data = '0;
    logic          drain_en = 1'b0;
    logic          rf_reg_write;
    logic [4:0]    rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic [4:0]    fwd_reg1 = '0;
    logic [4:0]    fwd_reg2 = '0;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [2:0]    count;

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .drain_en      (drain_en),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .fwd_reg1      (fwd_reg1),
        .fwd_reg2      (fwd_reg2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];   // model contents, oldest first
    ent_t sb[$];   // expected register-file writes, in order
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest queued write to a nonzero address wins; {hit, data}.
    function automatic logic [32:0] fwd_model(input logic [4:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (a != 5'd0 && mq[i].r == a) return {1'b1, mq[i].d};
        return 33'd0;
    endfunction

    // Monitor: every register-file write must be the next expected one.
    always @(negedge clk) begin
        if (chk_en && rf_reg_write === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rf_write", 32'(rf_write_reg), 32'hFFFF_FFFF);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("sb_rf_reg", 32'(rf_write_reg), 32'(e.r));
                chk("sb_rf_data", rf_write_data, e.d);
            end
        end
    end

    task automatic cycle(input bit rst, input bit vld, input logic [4:0] r, input logic [31:0] d,
                         input bit drn, input logic [4:0] f1, input logic [4:0] f2);
        int sz;
        logic [32:0] m1, m2;
        #1;
        reset = rst; in_valid = vld; in_reg = r; in_data = d;
        drain_en = drn; fwd_reg1 = f1; fwd_reg2 = f2;
        @(negedge clk);
        sz = mq.size();
        if (chk_en) begin
            m1 = fwd_model(f1);
            m2 = fwd_model(f2);
            chk("count", 32'(count), 32'(sz));
            chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
            chk("rf_reg_write", 32'(rf_reg_write), 32'(sz != 0 && drn));
            chk("rf_write_reg", 32'(rf_write_reg), (sz != 0) ? 32'(mq[0].r) : 32'd0);
            chk("rf_write_data", rf_write_data, (sz != 0) ? mq[0].d : 32'd0);
            chk("fwd_hit1", 32'(fwd_hit1), 32'(m1[32]));
            chk("fwd_data1", fwd_data1, m1[31:0]);
            chk("fwd_hit2", 32'(fwd_hit2), 32'(m2[32]));
            chk("fwd_data2", fwd_data2, m2[31:0]);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            sb.delete();
            chk_en = 1'b1;
        end else if (chk_en) begin
            if (sz != 0 && drn) void'(mq.pop_front());
            if (vld && sz != DEPTH && r != 5'd0) begin
                mq.push_back('{r: r, d: d});
                sb.push_back('{r: r, d: d});
            end
        end
    endtask

    initial begin
        // Reset held two cycles with a result offered.
        cycle(1, 1, 5'd9, 32'h1111, 1, 0, 0);
        cycle(1, 1, 5'd9, 32'h1111, 1, 9, 0);
        cycle(0, 0, 0, 0, 1, 9, 0);

        // Single result drains the cycle after enqueue.
        cycle(0, 1, 5'd5, 32'hDEAD_BEEF, 1, 5, 0);
        cycle(0, 0, 0, 0, 1, 5, 0);
        cycle(0, 0, 0, 0, 1, 5, 0);

        // Fill with drain held off, then offer a fifth.
        cycle(0, 1, 5'd3, 32'd1, 0, 3, 7);
        cycle(0, 1, 5'd3, 32'd2, 0, 3, 7);
        cycle(0, 1, 5'd7, 32'd9, 0, 3, 7);
        cycle(0, 1, 5'd3, 32'd4, 0, 3, 7);
        cycle(0, 1, 5'd9, 32'h99, 0, 3, 9);
        cycle(0, 0, 0, 0, 0, 3, 7);
        if (count !== 3'd4) chk("full_count", 32'(count), 32'd4);
        else chk("full_no_ready", 32'(in_ready), 32'd0);

        // Drain in order while forwarding r3 / r7.
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 1, 3, 7);

        // r0 handshake is swallowed.
        cycle(0, 1, 5'd0, 32'h55, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Pointer wrap with concurrent pops.
        for (int i = 0; i < 2 * DEPTH + 1; i++)
            cycle(0, 1, 5'(i % 31 + 1), $urandom, 1, 5'(i % 31 + 1), 5'(i % 31));
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Reset discards three queued entries.
        for (int i = 0; i < 3; i++) cycle(0, 1, 5'(i + 10), $urandom, 0, 10, 12);
        cycle(1, 0, 0, 0, 1, 10, 12);
        cycle(0, 0, 0, 0, 1, 10, 12);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  $urandom, ($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        // Flush and confirm every expected write appeared.
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
